// File: rtl/gate_op_arbiter.sv
// -----------------------------------------------------------------------------
// gate_op_arbiter
//
// Shares one WIDTH-bit bitwise logic unit (AND / OR / NOT) between NREQ
// requesters. One operation is in flight at a time. A requester is picked
// round-robin in IDLE, its operation is evaluated in a one-cycle EXEC stage,
// and the tagged result is then held on a valid/ready response port (RESP)
// until the consumer takes it.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset, aborts any in-flight operation
//   req_valid  [NREQ]        requester i has an operation pending
//   req_ready  [NREQ]        requester i accepted this cycle (one-hot or zero)
//   req_op     [2*NREQ]      requester i op in [2i+1:2i]:
//                            00 AND, 01 OR, 10 NOT(a), 11 reserved
//   req_a      [WIDTH*NREQ]  requester i operand a in slice i
//   req_b      [WIDTH*NREQ]  requester i operand b in slice i (unused for NOT)
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_id     [IDW]         index of the requester owning the result
//   rsp_data   [WIDTH]       result
//   rsp_err    op was reserved
//   busy       high in EXEC and RESP
// -----------------------------------------------------------------------------
module gate_op_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [2*NREQ-1:0]      req_op,
   input  logic [WIDTH*NREQ-1:0]  req_a,
   input  logic [WIDTH*NREQ-1:0]  req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_err,
   output logic                   busy
);

   localparam int unsigned NREQ_U = NREQ;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_NOT  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   state_t            state;
   logic [IDW-1:0]    last_grant;

   // Operation captured at the request handshake.
   op_t               lat_op;
   logic [WIDTH-1:0]  lat_a;
   logic [WIDTH-1:0]  lat_b;

   // Arbitration result for the current cycle.
   logic              sel_found;
   logic [IDW-1:0]    sel_idx;
   logic [NREQ-1:0]   grant_vec;
   logic [1:0]        sel_op;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;

   // -------------------------------------------------------------------------
   // Round-robin pick: scan from last_grant+1 upward, wrapping at NREQ. The
   // first hit wins, and only the winner's slice is routed to the operand
   // mux, so unselected requesters cannot leak X into the datapath.
   // -------------------------------------------------------------------------
   always_comb begin
      int unsigned cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      grant_vec = '0;
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= NREQ_U; k++) begin
         cand = 32'(last_grant) + k;
         if (cand >= NREQ_U) begin
            cand = cand - NREQ_U;
         end
         if (!sel_found && req_valid[IDW'(cand)]) begin
            sel_found             = 1'b1;
            sel_idx               = IDW'(cand);
            grant_vec[IDW'(cand)] = 1'b1;
            sel_op                = req_op[2*cand +: 2];
            sel_a                 = req_a[WIDTH*cand +: WIDTH];
            sel_b                 = req_b[WIDTH*cand +: WIDTH];
         end
      end
   end

   // Requests are only accepted while idle; the grant is visible the same
   // cycle the pick is made.
   always_comb begin
      req_ready = '0;
      if (state == IDLE) begin
         req_ready = grant_vec;
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM with registered response outputs. last_grant doubles as the
   // latched owner index of the in-flight operation.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         lat_op     <= OP_AND;
         lat_a      <= '0;
         lat_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  lat_op     <= op_t'(sel_op);
                  lat_a      <= sel_a;
                  lat_b      <= sel_b;
                  last_grant <= sel_idx;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end

            EXEC: begin
               case (lat_op)
                  OP_AND:  rsp_data <= lat_a & lat_b;
                  OP_OR:   rsp_data <= lat_a | lat_b;
                  OP_NOT:  rsp_data <= ~lat_a;
                  default: rsp_data <= '0;
               endcase
               rsp_err   <= (lat_op == OP_RSVD);
               rsp_id    <= last_grant;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // At most one requester is ever told it was accepted.
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

   // A held response must not change under backpressure.
   a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=>
         (rsp_valid && $stable(rsp_data) && $stable(rsp_id) && $stable(rsp_err)));

   // No acceptance while a result is outstanding.
   a_no_grant_busy: assert property (@(posedge clk) disable iff (!rst_n)
      busy |-> (req_ready == '0));
`endif

endmodule
